// File: rtl/multi_edge_detect.sv
// Multi-channel synchronised edge detector with sticky flags and event counter.
// Define EDGE_FILTER_EN to add a per-channel glitch filter of FILTER_LEN cycles.
module multi_edge_detect #(
  parameter int CHANNELS    = 6,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8,
  parameter int FILTER_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  din,
  input  logic [1:0]           mode,
  input  logic                 clear,
  output logic [CHANNELS-1:0]  pulse,
  output logic [CHANNELS-1:0]  sticky,
  output logic                 any_event,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  if (CHANNELS < 1 || CHANNELS > 32 || SYNC_STAGES < 2 ||
      CNT_WIDTH < 1 || FILTER_LEN < 2) begin : g_param_err
    $error("multi_edge_detect: illegal parameter value");
  end

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] lvl;
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] pulse_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN);

  logic [FW-1:0]       stab_q [CHANNELS];
  logic [CHANNELS-1:0] lvl_q;

  // l only follows s after FILTER_LEN consecutive cycles of disagreement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q <= '0;
      for (int c = 0; c < CHANNELS; c++) stab_q[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (s[c] == lvl_q[c]) begin
          stab_q[c] <= '0;
        end else if (stab_q[c] == FW'(FILTER_LEN - 1)) begin
          lvl_q[c]  <= s[c];
          stab_q[c] <= '0;
        end else begin
          stab_q[c] <= stab_q[c] + 1'b1;
        end
      end
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = s;
`endif

  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

  always_comb begin
    pulse_d = '0;
    unique case (mode)
      MODE_RISE: pulse_d = rise;
      MODE_FALL: pulse_d = fall;
      MODE_BOTH: pulse_d = rise | fall;
      MODE_OFF:  pulse_d = '0;
    endcase
  end

  // prev tracks in every mode so re-enabling never replays a stale edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= '0;
      pulse     <= '0;
      any_event <= 1'b0;
      sticky    <= '0;
      count     <= '0;
    end else begin
      prev_q    <= lvl;
      pulse     <= pulse_d;
      any_event <= |pulse_d;
      if (clear) sticky <= pulse;
      else       sticky <= sticky | pulse;
      if (clear) begin
        count <= CNT_WIDTH'(any_event);
      end else if (any_event && count != '1) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Randomised and directed bench for multi_edge_detect against a
// history-based reference model of the edge, sticky and counter rules.
module tb_multi_edge_detect;

  localparam int CH = 6;
  localparam int SY = 2;
  localparam int CW = 8;
  localparam int FL = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef EDGE_FILTER_EN
  localparam int HOLD  = FL;
  localparam int PEDGE = SY + FL + 1;
`else
  localparam int HOLD  = 1;
  localparam int PEDGE = SY + 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] din = '0;
  logic [1:0]    mode = 2'b00;
  logic          clear = 1'b0;
  logic [CH-1:0] pulse;
  logic [CH-1:0] sticky;
  logic          any_event;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;

  multi_edge_detect #(
    .CHANNELS(CH), .SYNC_STAGES(SY), .CNT_WIDTH(CW), .FILTER_LEN(FL)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .mode(mode), .clear(clear),
    .pulse(pulse), .sticky(sticky), .any_event(any_event), .count(count)
  );

  always #5 clk = ~clk;

  // model: din sampled per edge, filtered level per edge, outputs
  logic [CH-1:0] din_h [$];
  logic [CH-1:0] l_h [$];
  int            k;
  logic [CH-1:0] m_pulse;
  logic [CH-1:0] m_sticky;
  logic          m_any;
  int            m_cnt;

  function automatic logic [CH-1:0] s_at(int e);
    int idx = e - SY + 1;
    if (idx < 1 || idx >= din_h.size()) return '0;
    return din_h[idx];
  endfunction

  function automatic logic [CH-1:0] l_at(int e);
    if (e < 0 || e >= l_h.size()) return '0;
    return l_h[e];
  endfunction

  task automatic model_init();
    k = 0;
    din_h.delete();
    l_h.delete();
    din_h.push_back('0);
    l_h.push_back('0);
    m_pulse = '0;
    m_sticky = '0;
    m_any = 1'b0;
    m_cnt = 0;
  endtask

  task automatic tick();
    logic [CH-1:0] d, lk, lc, lp, np;
    logic [1:0] md;
    logic cl;
    d = din; md = mode; cl = clear;
    @(posedge clk);
    k++;
    din_h.push_back(d);
`ifdef EDGE_FILTER_EN
    lk = l_at(k - 1);
    for (int c = 0; c < CH; c++) begin
      logic diff;
      diff = 1'b1;
      for (int j = 1; j <= FL; j++) begin
        logic [CH-1:0] sv;
        sv = s_at(k - j);
        if (sv[c] == lk[c]) diff = 1'b0;
      end
      if (diff) lk[c] = ~lk[c];
    end
`else
    lk = s_at(k);
`endif
    lc = l_at(k - 1);
    lp = l_at(k - 2);
    case (md)
      2'd0: np = lc & ~lp;
      2'd1: np = ~lc & lp;
      2'd2: np = lc ^ lp;
      default: np = '0;
    endcase
    if (cl) begin
      m_sticky = m_pulse;
      m_cnt = m_any ? 1 : 0;
    end else begin
      m_sticky = m_sticky | m_pulse;
      if (m_any && m_cnt < CMAX) m_cnt = m_cnt + 1;
    end
    m_pulse = np;
    m_any = |np;
    l_h.push_back(lk);
    #1;
  endtask

  task automatic apply_reset(input logic [CH-1:0] d, input logic [1:0] md);
    reset = 1'b1;
    din = d;
    mode = md;
    clear = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_init();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    din = CH'($urandom);
    mode = 2'($urandom);
    #23;
    tests++;
    if (pulse !== '0) begin
      fails++; $display("FAIL reset_pulse got %b want 0", pulse);
    end
    tests++;
    if (sticky !== '0) begin
      fails++; $display("FAIL reset_sticky got %b want 0", sticky);
    end
    tests++;
    if (any_event !== 1'b0) begin
      fails++; $display("FAIL reset_any got %b want 0", any_event);
    end
    tests++;
    if (count !== '0) begin
      fails++; $display("FAIL reset_count got %0d want 0", count);
    end
  endtask

  task automatic test_rise_hold();
    apply_reset(6'b000001, 2'b00);
    for (int i = 1; i <= PEDGE + 3; i++) begin
      logic [CH-1:0] want;
      tick();
      want = (i == PEDGE) ? 6'b000001 : 6'b000000;
      tests++;
      if (pulse !== want) begin
        fails++; $display("FAIL rise_pulse edge %0d got %b want %b", i, pulse, want);
      end
      tests++;
      if (any_event !== m_any) begin
        fails++; $display("FAIL rise_any edge %0d got %b want %b", i, any_event, m_any);
      end
    end
    tests++;
    if (sticky !== 6'b000001) begin
      fails++; $display("FAIL rise_sticky got %b want 000001", sticky);
    end
    tests++;
    if (count !== CW'(1)) begin
      fails++; $display("FAIL rise_count got %0d want 1", count);
    end
  endtask

  task automatic test_fall();
    int seen = 0;
    apply_reset('0, 2'b01);
    for (int i = 0; i < 30; i++) begin
      if (i == 0) din[1] = 1'b1;
      if (i == 8 + HOLD) din[1] = 1'b0;
      tick();
      if (pulse[1]) seen++;
      tests++;
      if (pulse !== m_pulse) begin
        fails++; $display("FAIL fall_pulse cyc %0d got %b want %b", i, pulse, m_pulse);
      end
    end
    tests++;
    if (seen != 1 || count !== CW'(1)) begin
      fails++; $display("FAIL fall_once pulses %0d count %0d want 1 1", seen, count);
    end
  endtask

  task automatic test_toggle_modes();
    apply_reset('0, 2'b10);
    for (int t = 0; t < 6; t++) begin
      din[2] = ~din[2];
      repeat (4) begin
        tick();
        tests++;
        if (pulse !== m_pulse) begin
          fails++; $display("FAIL both_pulse got %b want %b", pulse, m_pulse);
        end
      end
    end
    repeat (10) tick();
    tests++;
    if (count !== CW'(6)) begin
      fails++; $display("FAIL both_count got %0d want 6", count);
    end
    mode = 2'b11;
    for (int t = 0; t < 4; t++) begin
      din[2] = ~din[2];
      repeat (4) begin
        tick();
        tests++;
        if (pulse !== '0) begin
          fails++; $display("FAIL off_pulse got %b want 0", pulse);
        end
      end
    end
    repeat (10) tick();
    mode = 2'b10;
    repeat (4) begin
      tick();
      tests++;
      if (pulse !== '0 || count !== CW'(6)) begin
        fails++; $display("FAIL off_hold pulse %b count %0d want 0 6", pulse, count);
      end
    end
  endtask

  task automatic test_clear_coincide();
    bit found = 0;
    apply_reset('0, 2'b00);
    repeat (5) begin
      din[0] = 1'b1;
      repeat (HOLD) tick();
      din[0] = 1'b0;
      repeat (HOLD) tick();
    end
    repeat (12) tick();
    din[3] = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (pulse[3]) found = 1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL clr_wait no pulse[3] within 20 cycles");
    end
    tests++;
    if (count !== CW'(5)) begin
      fails++; $display("FAIL clr_pre_count got %0d want 5", count);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++;
    if (sticky !== 6'b001000 || count !== CW'(1)) begin
      fails++; $display("FAIL clr_evt sticky %b count %0d want 001000 1", sticky, count);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++;
    if (sticky !== '0 || count !== '0) begin
      fails++; $display("FAIL clr_only sticky %b count %0d want 0 0", sticky, count);
    end
  endtask

  task automatic test_saturate();
    apply_reset('0, 2'b00);
    repeat (300) begin
      din[0] = 1'b1;
      repeat (HOLD) tick();
      din[0] = 1'b0;
      repeat (HOLD) tick();
    end
    repeat (12) tick();
    tests++;
    if (count !== CW'(CMAX) || int'(count) != m_cnt) begin
      fails++; $display("FAIL sat_count got %0d want %0d", count, CMAX);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    din = 6'b010001;
    repeat (12) tick();
    tests++;
    if (count !== CW'(1) || sticky !== 6'b010001) begin
      fails++; $display("FAIL coincide count %0d sticky %b want 1 010001", count, sticky);
    end
  endtask

  task automatic test_random();
    apply_reset(CH'($urandom), 2'($urandom));
    for (int i = 0; i < 600; i++) begin
      din = din ^ (CH'($urandom) & CH'($urandom) & CH'($urandom));
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      clear = ($urandom_range(0, 15) == 0);
      tick();
      tests++;
      if (pulse !== m_pulse || any_event !== m_any) begin
        fails++;
        $display("FAIL rnd_pulse cyc %0d got %b/%b want %b/%b", i, pulse, any_event, m_pulse, m_any);
      end
      tests++;
      if (sticky !== m_sticky || int'(count) != m_cnt) begin
        fails++;
        $display("FAIL rnd_state cyc %0d got %b/%0d want %b/%0d", i, sticky, count, m_sticky, m_cnt);
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found = 0;
    apply_reset('0, 2'b00);
    din = 6'b100110;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (pulse != '0) found = 1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL arst_wait no pulse within 20 cycles");
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (pulse !== '0 || sticky !== '0 || any_event !== 1'b0 || count !== '0) begin
      fails++;
      $display("FAIL arst_clear got %b %b %b %0d want all 0", pulse, sticky, any_event, count);
    end
    apply_reset('0, 2'b00);
  endtask

`ifdef EDGE_FILTER_EN
  task automatic test_filter();
    apply_reset('0, 2'b00);
    din[5] = 1'b1;
    repeat (2) tick();
    din[5] = 1'b0;
    repeat (12) begin
      tick();
      tests++;
      if (pulse !== '0) begin
        fails++; $display("FAIL glitch_pulse got %b want 0", pulse);
      end
    end
    din[5] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      logic [CH-1:0] want;
      if (i == 5) din[5] = 1'b0;
      tick();
      want = (i == SY + FL + 1) ? 6'b100000 : 6'b000000;
      tests++;
      if (pulse !== want) begin
        fails++; $display("FAIL filt_pulse edge %0d got %b want %b", i, pulse, want);
      end
    end
  endtask
`endif

  initial begin
    model_init();
    test_reset();
    test_rise_hold();
    test_fall();
    test_toggle_modes();
    test_clear_coincide();
    test_saturate();
    test_random();
    test_async_reset();
`ifdef EDGE_FILTER_EN
    test_filter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_edge_detect.md
# multi_edge_detect

Parametrised multi-channel edge detector; successor to the single-purpose rising-edge block. Each channel passes through a reset-cleared synchroniser, then generates a registered one-cycle pulse on rising, falling or both edges, selected at run time. Pulses also set per-channel sticky flags and advance a saturating global event counter. It sits directly behind the chip's raw input pins, ahead of any logic that consumes edge events.

## Interface
- `CHANNELS`, 6: number of independent input channels (1..32).
- `SYNC_STAGES`, 2: synchroniser depth (>=2).
- `CNT_WIDTH`, 8: event counter width (>=1).
- `FILTER_LEN`, 4: glitch-filter stability length in cycles (>=2). Used only with `EDGE_FILTER_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `din`  in  CHANNELS  raw asynchronous channel inputs.
- `mode`  in  2  edge select: 00 rising, 01 falling, 10 both, 11 disabled.
- `clear`  in  1  synchronous clear of `sticky` and `count`.
- `pulse`  out  CHANNELS  registered one-cycle edge pulse per channel.
- `sticky`  out  CHANNELS  latched event flag per channel.
- `any_event`  out  1  registered OR of the next-state `pulse` bits; coincident with `pulse`.
- `count`  out  CNT_WIDTH  number of cycles in which `any_event` was high, saturating.

## Operation
- Reset values: synchroniser flops, previous-level flops, filter state, `pulse`, `sticky`, `any_event` and `count` are all 0.
- A channel held high through reset release is therefore reported as a rising edge.
- Per channel: `din` passes through a `SYNC_STAGES` flop chain to give the synced level `s`. The level `l` equals `s`, or the filtered level when the filter is enabled. A previous-level register `p` captures `l` every cycle.
- Edge terms: rise = `l & ~p`; fall = `~l & p`. The `pulse` next-state is rise (00), fall (01), rise|fall (10) or 0 (11).
- `sticky[i]` is set by `pulse[i]` and cleared by `clear`. When both occur in the same cycle, set wins.
- `count` increments by 1 per cycle with `any_event` high, regardless of how many channels pulse together.
  - It holds at 2^CNT_WIDTH-1 once saturated.
  - `clear` together with an event loads 1.
  - `clear` alone loads 0.
- Mode changes take effect at the next clock edge. A mode change never creates a pulse by itself. Synchroniser and `p` keep tracking in mode 11, so re-enabling does not replay old edges.
- Asserting `reset` mid-operation clears everything asynchronously. Deassertion restarts as from power-up.

## Timing
- Number clock edges from 1, where edge 1 is the first to sample the new `din` level.
- Without filter: `pulse` rises on edge SYNC_STAGES+1 and is high for exactly one cycle. That is edge 3 at defaults.
- With filter: `pulse` rises on edge SYNC_STAGES+FILTER_LEN+1. That is edge 7 at defaults.
- `sticky` sets on the edge after the pulse. `count` increments on the edge after the pulse, and both are visible in the cycle after `pulse`.
- `clear` sampled on edge N affects `sticky` and `count` from edge N onward.
- Back-to-back toggles produce back-to-back pulses; there is no minimum spacing without the filter.

## Configuration
- `EDGE_FILTER_EN` defined:
  - Each channel gets a stability counter.
  - While `s != l`, the counter increments each cycle. When `s` has differed from `l` for FILTER_LEN consecutive cycles, `l` takes `s` and the counter resets.
  - The counter also resets whenever `s == l`.
  - Synced pulses shorter than FILTER_LEN cycles produce no edge.
- `EDGE_FILTER_EN` undefined: `l = s`. No filter logic is generated, and `FILTER_LEN` is ignored.

## Test plan
- Reset, mode=00, `din`=000001 held: `pulse`=000001 for exactly one cycle at edge 3; then `sticky`=000001, `count`=1, `any_event` high coincident with the pulse.
- mode=01, channel 1 driven 0→1→0 with 8 cycles between transitions: single `pulse[1]` at edge 3 after the fall only; `count`=1.
- mode=10, channel 2 toggled every 4 cycles, 6 transitions: 6 single-cycle pulses; `count`=6. Then mode=11 with 4 more toggles: no pulses; `count` stays 6.
- `clear` asserted in the same cycle `pulse[3]` is high, with `count`=5 beforehand: `sticky[3]`=1, `count`=1. `clear` alone on the next cycle: `sticky`=0, `count`=0.
- CNT_WIDTH=8, 300 rising events on channel 0: `count`=255 and holds. Channels 0 and 4 rising simultaneously: one increment.
- `reset` asserted between edges mid-pulse: all outputs 0 before the next edge. With `EDGE_FILTER_EN`: a 2-cycle high glitch gives no pulse; a 4-cycle high gives a pulse at edge 7.
